dsum3: RTL and testbench
========================

# dsum3

Chained sign-magnitude integrator: the inverse of the three-stage delayed-difference chain. It accumulates a third-difference stream three times to rebuild the original sample stream. It sits on the reconstruction side of the ANS/PWM datapath, taking `dd3`/`dd3s`-style input. Each stage is pipelined and valid-qualified, saturating and clearable.

## Interface
- `W`, 16, magnitude width of the input, the output and each accumulator.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `clr` input 1: synchronous clear of all accumulators, the valid pipeline and `sat`.
- `in_valid` input 1: `D`/`D_sign` hold a sample this cycle.
- `D` input W: input magnitude.
- `D_sign` input 1: input sign, 1 = negative.
- `A` output W: reconstructed magnitude.
- `A_sign` output 1: reconstructed sign.
- `out_valid` output 1: `A`/`A_sign` were updated with a new sample this cycle.
- `sat` output 1: sticky flag, set when any stage has saturated.

## Operation
- **Internal format:** three accumulators `acc1..acc3`, each two's complement W+1 bits.
  - Legal range is −(2^W−1)..+(2^W−1), i.e. −65535..65535.
  - Sign-magnitude input converts to two's complement. `D=0, D_sign=1` (negative zero) is treated as 0.
- **Stage update, k = 1..3:** when `v(k-1)` is high, `acc_k <= sat(acc_k + in_k)`.
  - `in_1` = converted input, `v0 = in_valid`.
  - `in_2 = acc1`, `in_3 = acc2`, each using the register value after that stage's update.
- **Valid pipeline:** `v1`, `v2`, `v3` are registered copies of `v0`, `v1`, `v2`.
  - A stage whose qualifying valid is low holds its value, so input bubbles are transparent.
- **Saturation:**
  - A sum above +65535 is clamped to +65535; below −65535 is clamped to −65535.
  - Any clamp in any stage sets `sat`. `sat` stays set until `clr` or reset.
- **Output conversion:**
  - `A = |acc3|`, `A_sign = (acc3 < 0)`.
  - Zero is always output with `A_sign = 0`.
  - The outputs hold the last value while `out_valid` is low.
- **Clear:** `clr` high at a clock edge zeroes `acc1..3`, `v1..v3`, `out_valid` and `sat`.
  - `clr` has priority. An `in_valid` sample in the same cycle is dropped.
  - Samples in flight are discarded.
- **Reset:** `rst_n` low forces the same state asynchronously, at any time, including mid-pipeline.
  - Reset values: `A=0`, `A_sign=0`, `out_valid=0`, `sat=0`, all accumulators 0.
- **Round-trip contract:** after a common reset, feeding the difference chain's third-difference output into this block reproduces the original stream exactly, provided no saturation occurs.

## Timing
- **Latency:** 3 cycles.
  - `in_valid` sampled at edge k → `acc1` updates at k.
  - `acc2` updates at k+1.
  - `acc3`, `A`, `A_sign` update at k+2, with `out_valid` high in the cycle following edge k+2.
- **Throughput:** one sample per clock. Back-to-back `in_valid` yields back-to-back `out_valid`.
- **Outputs:** `A`, `A_sign`, `out_valid` and `sat` are all registered, with no combinational path from the inputs.
- **Saturation flag timing:** `sat` rises in the same cycle as the clamped accumulator value becomes visible.
- **Reset release:** the first edge after `rst_n` deasserts may sample `in_valid`.

## Test plan
- **Impulse:** `D=1` for one valid cycle, then `D=0` with valid held → `A` = 1, 3, 6, 10, 15, 21 on consecutive `out_valid` cycles, first output 3 cycles after the impulse, `sat=0`.
- **Round trip:** third differences of ramp 0, 10, 20, 30, i.e. `D` = 0, +10, −10 (`D_sign=1`), 0 → `A` = 0, 10, 20, 30 with `A_sign=0`.
- **Negative output:** single `D=5, D_sign=1`, then zeros → `A` = 5, 15, 30 with `A_sign=1`.
- **Negative zero:** `D=0, D_sign=1` for 4 cycles → `A=0, A_sign=0` throughout.
- **Saturation:** `D=65535` held valid → `acc1` reaches +65535, then `acc2` clamps → `sat=1`, `A` settles at 65535; `clr` pulse → `sat=0`, `A=0` at the next output.
- **Bubbles, clear and reset:**
  - Impulse `D=1` with `in_valid` toggling 1,0,1,0 (zeros on valid cycles) → same `A` sequence 1, 3, 6 on the `out_valid` cycles.
  - `clr` coincident with `in_valid` → that sample is absent from the output.
  - `rst_n` pulsed low mid-stream → all outputs 0 immediately, no `out_valid` until 3 cycles after the next sample.

Source files
------------

// File: rtl/dsum3_if.sv
// dsum3_if: sample stream into the dsum3 integrator and its reconstructed output.
//   master drives in_valid/D/D_sign and observes A/A_sign/out_valid/sat.
//   slave (the integrator) consumes the sample and drives the registered outputs.
interface dsum3_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] D;
  logic         D_sign;
  logic [W-1:0] A;
  logic         A_sign;
  logic         out_valid;
  logic         sat;

  modport master (
    output in_valid, D, D_sign,
    input  A, A_sign, out_valid, sat
  );

  modport slave (
    input  in_valid, D, D_sign,
    output A, A_sign, out_valid, sat
  );
endinterface

// File: rtl/dsum3.sv
// dsum3: triple saturating integrator rebuilding a stream from its sign-magnitude third difference.
// Latency: 3 cycles from an accepted in_valid sample to out_valid; one sample per clock.
// Backpressure: none; every in_valid sample is taken, bubbles pass through transparently.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   clr         - synchronous clear of accumulators, valid pipeline and sat (wins over in_valid)
//   io (slave)  - in_valid/D/D_sign sample in; A/A_sign/out_valid/sat registered out
module dsum3 #(
  parameter int W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  dsum3_if.slave io
);

  // Accumulators hold W+1-bit two's complement; sums need one more bit to see overflow.
  localparam int AW = W + 1;
  localparam int SW = W + 2;

  typedef logic signed [AW-1:0] acc_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t POS_LIM = {2'b00, {W{1'b1}}};
  localparam sum_t NEG_LIM = -POS_LIM;

  acc_t acc1, acc2, acc3;
  logic v1, v2;

  acc_t         in1;
  sum_t         sum1, sum2, sum3;
  acc_t         nxt1, nxt2, nxt3;
  logic         clip1, clip2, clip3;
  acc_t         neg3;
  logic [W-1:0] a_mag;

  function automatic acc_t clamp(input sum_t s);
    sum_t r;
    r = s;
    if (s > POS_LIM) r = POS_LIM;
    else if (s < NEG_LIM) r = NEG_LIM;
    return r[AW-1:0];
  endfunction

  function automatic logic over(input sum_t s);
    return (s > POS_LIM) || (s < NEG_LIM);
  endfunction

  always_comb begin
    // Negating a zero magnitude gives zero, so negative zero needs no special case.
    in1 = io.D_sign ? -acc_t'({1'b0, io.D}) : acc_t'({1'b0, io.D});

    // Each stage adds the upstream register as it stands now, i.e. the value the
    // upstream stage produced for this same sample one edge earlier.
    sum1 = {acc1[AW-1], acc1} + {in1[AW-1], in1};
    sum2 = {acc2[AW-1], acc2} + {acc1[AW-1], acc1};
    sum3 = {acc3[AW-1], acc3} + {acc2[AW-1], acc2};

    nxt1  = clamp(sum1);
    nxt2  = clamp(sum2);
    nxt3  = clamp(sum3);
    clip1 = over(sum1);
    clip2 = over(sum2);
    clip3 = over(sum3);

    // Clamping keeps acc3 >= -(2^W-1), so its negation always fits in W bits.
    neg3  = -nxt3;
    a_mag = nxt3[AW-1] ? neg3[W-1:0] : nxt3[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1         <= '0;
      acc2         <= '0;
      acc3         <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      io.A         <= '0;
      io.A_sign    <= 1'b0;
      io.out_valid <= 1'b0;
      io.sat       <= 1'b0;
    end else if (clr) begin
      acc1         <= '0;
      acc2         <= '0;
      acc3         <= '0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      io.A         <= '0;
      io.A_sign    <= 1'b0;
      io.out_valid <= 1'b0;
      io.sat       <= 1'b0;
    end else begin
      if (io.in_valid) acc1 <= nxt1;
      if (v1)          acc2 <= nxt2;
      if (v2) begin
        acc3      <= nxt3;
        io.A      <= a_mag;
        io.A_sign <= nxt3[AW-1];  // negative implies nonzero, so zero never carries a sign
      end
      v1           <= io.in_valid;
      v2           <= v1;
      io.out_valid <= v2;
      // Flag rises on the same edge the clamped value is registered.
      if ((io.in_valid && clip1) || (v1 && clip2) || (v2 && clip3))
        io.sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsum3.sv
// tb_dsum3: bench for dsum3; directed scenarios plus randomized stream checked
// against a behavioural triple-running-sum model.
module tb_dsum3;
  localparam int W    = 16;
  localparam int MAXV = 65535;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  dsum3_if #(.W(W)) io();

  dsum3 #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .io   (io)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Captured outputs
  int got_a[$];
  bit got_s[$];
  int got_c[$];
  // Model expectations
  int exp_a[$];
  bit exp_s[$];
  int s1, s2, s3;
  bit msat;

  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      got_a.push_back(int'(io.A));
      got_s.push_back(io.A_sign);
      got_c.push_back(cyc);
    end
  end

  function automatic int clampv(input int v);
    if (v > MAXV) begin msat = 1'b1; return MAXV; end
    if (v < -MAXV) begin msat = 1'b1; return -MAXV; end
    return v;
  endfunction

  // Three running sums applied in order for each accepted sample.
  task automatic model_step(input int x);
    s1 = clampv(s1 + x);
    s2 = clampv(s2 + s1);
    s3 = clampv(s3 + s2);
    exp_a.push_back(s3 < 0 ? -s3 : s3);
    exp_s.push_back(s3 < 0);
  endtask

  task automatic model_reset();
    s1 = 0; s2 = 0; s3 = 0; msat = 1'b0;
    exp_a.delete(); exp_s.delete();
  endtask

  task automatic drive(input bit v, input int mag, input bit sgn, input bit c);
    @(negedge clk);
    io.in_valid = v;
    io.D        = mag[W-1:0];
    io.D_sign   = sgn;
    clr         = c;
    if (c) model_reset();
    else if (v) model_step(sgn ? -mag : mag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic start_test();
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
    got_a.delete(); got_s.delete(); got_c.delete();
    model_reset();
  endtask

  task automatic test_reset();
    io.in_valid = 1'b0; io.D = '0; io.D_sign = 1'b0;
    #23;
    tests_run++;
    if (io.A !== 16'd0 || io.A_sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_a: got A=%0d sign=%0b, want 0/0", io.A, io.A_sign);
    end
    tests_run++;
    if (io.out_valid !== 1'b0 || io.sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got out_valid=%0b sat=%0b, want 0/0", io.out_valid, io.sat);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    int want[6] = '{1, 3, 6, 10, 15, 21};
    int c0;
    start_test();
    drive(1'b1, 1, 1'b0, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 5; i++) drive(1'b1, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 6) begin
      tests_failed++;
      $display("FAIL impulse_count: got %0d outputs, want 6", got_a.size());
    end else begin
      tests_run++;
      if (got_c[0] != c0 + 3) begin
        tests_failed++;
        $display("FAIL impulse_latency: got cycle %0d, want %0d", got_c[0], c0 + 3);
      end
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (got_a[i] != want[i] || got_s[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL impulse[%0d]: got %0d sign %0b, want %0d sign 0", i, got_a[i], got_s[i], want[i]);
        end
      end
    end
    tests_run++;
    if (io.sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL impulse_sat: got %0b, want 0", io.sat);
    end
  endtask

  task automatic test_round_trip();
    int want[4] = '{0, 10, 20, 30};
    start_test();
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b1, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 4) begin
      tests_failed++;
      $display("FAIL round_trip_count: got %0d outputs, want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_a[i] != want[i] || got_s[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL round_trip[%0d]: got %0d sign %0b, want %0d sign 0", i, got_a[i], got_s[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_negative();
    int want[3] = '{5, 15, 30};
    start_test();
    drive(1'b1, 5, 1'b1, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 3) begin
      tests_failed++;
      $display("FAIL negative_count: got %0d outputs, want 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_a[i] != want[i] || got_s[i] !== 1'b1) begin
          tests_failed++;
          $display("FAIL negative[%0d]: got %0d sign %0b, want %0d sign 1", i, got_a[i], got_s[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_neg_zero();
    start_test();
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 1'b1, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 4) begin
      tests_failed++;
      $display("FAIL neg_zero_count: got %0d outputs, want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_a[i] != 0 || got_s[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL neg_zero[%0d]: got %0d sign %0b, want 0 sign 0", i, got_a[i], got_s[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    start_test();
    for (int i = 0; i < 8; i++) drive(1'b1, MAXV, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != exp_a.size()) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d outputs, want %0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < got_a.size(); i++) begin
        tests_run++;
        if (got_a[i] != exp_a[i] || got_s[i] !== exp_s[i]) begin
          tests_failed++;
          $display("FAIL sat_val[%0d]: got %0d sign %0b, want %0d sign %0b", i, got_a[i], got_s[i], exp_a[i], exp_s[i]);
        end
      end
    end
    tests_run++;
    if (io.sat !== 1'b1 || io.A !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL sat_flag: got sat=%0b A=%0d, want sat=1 A=65535", io.sat, io.A);
    end
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
    tests_run++;
    if (io.sat !== 1'b0 || io.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_clr: got sat=%0b out_valid=%0b, want 0/0", io.sat, io.out_valid);
    end
    got_a.delete(); got_s.delete(); got_c.delete();
    drive(1'b1, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 1 || io.A !== 16'd0 || io.sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_after_clr: got %0d outputs A=%0d sat=%0b, want 1 output A=0 sat=0", got_a.size(), io.A, io.sat);
    end
  endtask

  task automatic test_bubbles();
    int want[3] = '{1, 3, 6};
    start_test();
    drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 3) begin
      tests_failed++;
      $display("FAIL bubbles_count: got %0d outputs, want 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_a[i] != want[i]) begin
          tests_failed++;
          $display("FAIL bubbles[%0d]: got %0d, want %0d", i, got_a[i], want[i]);
        end
      end
      tests_run++;
      if (got_c[1] - got_c[0] != 2) begin
        tests_failed++;
        $display("FAIL bubbles_spacing: got %0d cycles, want 2", got_c[1] - got_c[0]);
      end
    end
  endtask

  task automatic test_clr_coincident();
    start_test();
    drive(1'b1, 3, 1'b0, 1'b0);  // in flight when clr hits: must vanish
    drive(1'b1, 7, 1'b0, 1'b1);  // coincident with clr: dropped
    drive(1'b1, 2, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0);
    idle(5);
    tests_run++;
    if (got_a.size() != 2) begin
      tests_failed++;
      $display("FAIL clr_count: got %0d outputs, want 2", got_a.size());
    end else begin
      tests_run++;
      if (got_a[0] != 2 || got_a[1] != 6) begin
        tests_failed++;
        $display("FAIL clr_vals: got %0d,%0d, want 2,6", got_a[0], got_a[1]);
      end
    end
  endtask

  task automatic test_random();
    int mag;
    bit v, sg;
    start_test();
    for (int i = 0; i < 80; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      mag = $urandom_range(0, 40);
      sg  = $urandom_range(0, 1);
      drive(v, mag, sg, 1'b0);
    end
    idle(5);
    tests_run++;
    if (got_a.size() != exp_a.size()) begin
      tests_failed++;
      $display("FAIL random_count: got %0d outputs, want %0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < got_a.size(); i++) begin
        tests_run++;
        if (got_a[i] != exp_a[i] || got_s[i] !== exp_s[i]) begin
          tests_failed++;
          $display("FAIL random[%0d]: got %0d sign %0b, want %0d sign %0b", i, got_a[i], got_s[i], exp_a[i], exp_s[i]);
        end
      end
    end
    tests_run++;
    if (io.sat !== msat) begin
      tests_failed++;
      $display("FAIL random_sat: got %0b, want %0b", io.sat, msat);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    start_test();
    for (int i = 0; i < 4; i++) drive(1'b1, 1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    io.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (io.A !== 16'd0 || io.A_sign !== 1'b0 || io.out_valid !== 1'b0 || io.sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got A=%0d sign=%0b ov=%0b sat=%0b, want all 0", io.A, io.A_sign, io.out_valid, io.sat);
    end
    @(negedge clk) rst_n = 1'b1;
    got_a.delete(); got_s.delete(); got_c.delete();
    model_reset();
    drive(1'b1, 9, 1'b0, 1'b0);
    c0 = cyc;
    idle(6);
    tests_run++;
    if (got_a.size() != 1) begin
      tests_failed++;
      $display("FAIL reset_mid_count: got %0d outputs, want 1", got_a.size());
    end else begin
      tests_run++;
      if (got_c[0] != c0 + 3 || got_a[0] != 9) begin
        tests_failed++;
        $display("FAIL reset_mid_out: got A=%0d at cycle %0d, want 9 at %0d", got_a[0], got_c[0], c0 + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_round_trip();
    test_negative();
    test_neg_zero();
    test_saturation();
    test_bubbles();
    test_clr_coincident();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
